// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  localparam logic PORT_C = 1'b0;
  localparam logic PORT_B = 1'b1;

  localparam int unsigned ADDR_W_DEF   = 32;
  localparam int unsigned DATA_W_DEF   = 32;
  localparam int unsigned MAX_LOCK_DEF = 8;

endpackage

// File: rtl/arb_pick.sv
// Winner selection for the data-memory arbiter (purely combinational).
module arb_pick
  import dmem_arb_pkg::*;
(
  input  logic       i_c_req,
  input  logic       i_b_req,
  input  logic       i_last,
  input  arb_state_e i_state,
  input  logic       i_lock_max,
  output logic [1:0] o_win
);

  // One-hot winner: round-robin in ARB, bridge-owned with core escape in LOCK.
  always_comb begin
    o_win = 2'b00;
    if (i_state == LOCK) begin
      if (i_c_req && (i_lock_max || !i_b_req)) begin
        o_win[PORT_C] = 1'b1;
      end else if (i_b_req) begin
        o_win[PORT_B] = 1'b1;
      end
    end else if (i_c_req && i_b_req) begin
      if (i_last == PORT_B) begin
        o_win[PORT_C] = 1'b1;
      end else begin
        o_win[PORT_B] = 1'b1;
      end
    end else begin
      o_win[PORT_C] = i_c_req;
      o_win[PORT_B] = i_b_req;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-port data memory between the core (C) and the I2C bridge (B).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned MAX_LOCK = MAX_LOCK_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_stall,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              b_req,
  input  logic              b_lock,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CNT_W = $clog2(MAX_LOCK + 1);

  arb_state_e        r_state;
  arb_state_e        w_state_nxt;
  logic              r_last;
  logic              w_last_nxt;
  logic [CNT_W-1:0]  r_lock_cnt;
  logic [CNT_W-1:0]  w_lock_cnt_nxt;
  logic              w_lock_max;
  logic [1:0]        w_win;
  logic              w_c_gnt;
  logic              w_b_gnt;
  logic              r_c_rvalid;
  logic              r_b_rvalid;
  logic [DATA_W-1:0] r_c_rdata;
  logic [DATA_W-1:0] r_b_rdata;

  assign w_lock_max = (r_lock_cnt == CNT_W'(MAX_LOCK));

  arb_pick u_pick (
    .i_c_req    (c_req),
    .i_b_req    (b_req),
    .i_last     (r_last),
    .i_state    (r_state),
    .i_lock_max (w_lock_max),
    .o_win      (w_win)
  );

  // Grants are killed immediately while reset is low so no write can commit.
  assign w_c_gnt = reset & w_win[PORT_C];
  assign w_b_gnt = reset & w_win[PORT_B];

  assign c_gnt    = w_c_gnt;
  assign b_gnt    = w_b_gnt;
  assign c_stall  = c_req & ~w_c_gnt;
  assign c_rvalid = r_c_rvalid;
  assign b_rvalid = r_b_rvalid;
  assign c_rdata  = r_c_rdata;
  assign b_rdata  = r_b_rdata;

  // Memory port mux: the granted requester drives the memory, idle is all-zero.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_c_gnt) begin
      mem_we    = c_we;
      mem_addr  = c_addr;
      mem_wdata = c_wdata;
    end else if (w_b_gnt) begin
      mem_we    = b_we;
      mem_addr  = b_addr;
      mem_wdata = b_wdata;
    end
  end

  // Arbitration state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ARB;
      r_last     <= PORT_B;
      r_lock_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_last     <= w_last_nxt;
      r_lock_cnt <= w_lock_cnt_nxt;
    end
  end

  // Next state, last winner and lock counter.
  always_comb begin
    w_state_nxt    = r_state;
    w_last_nxt     = r_last;
    w_lock_cnt_nxt = r_lock_cnt;
    if (w_c_gnt) begin
      w_last_nxt = PORT_C;
    end else if (w_b_gnt) begin
      w_last_nxt = PORT_B;
    end
    case (r_state)
      ARB: begin
        if (w_b_gnt && b_lock) begin
          w_state_nxt    = LOCK;
          w_lock_cnt_nxt = CNT_W'(1);
        end
      end
      LOCK: begin
        if (w_b_gnt && !w_lock_max) begin
          w_lock_cnt_nxt = r_lock_cnt + CNT_W'(1);
        end else if (w_c_gnt) begin
          w_lock_cnt_nxt = '0;
        end
        if (!(b_req && b_lock)) begin
          w_state_nxt    = ARB;
          w_lock_cnt_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = ARB;
      end
    endcase
  end

  // Read capture: data registered on the read-grant edge, valid for one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_c_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
      r_c_rdata  <= '0;
      r_b_rdata  <= '0;
    end else begin
      r_c_rvalid <= w_c_gnt & ~c_we;
      r_b_rvalid <= w_b_gnt & ~b_we;
      if (w_c_gnt && !c_we) begin
        r_c_rdata <= mem_rdata;
      end
      if (w_b_gnt && !b_we) begin
        r_b_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with an ownership-level reference model.
module tb_dmem_arbiter;

  localparam int unsigned MAX_LOCK = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        c_req = 1'b0, c_we = 1'b0;
  logic [31:0] c_addr = '0, c_wdata = '0;
  logic        b_req = 1'b0, b_lock = 1'b0, b_we = 1'b0;
  logic [31:0] b_addr = '0, b_wdata = '0;
  logic        c_gnt, c_stall, c_rvalid, b_gnt, b_rvalid, mem_we;
  logic [31:0] c_rdata, b_rdata, mem_addr, mem_wdata, mem_rdata;

  logic [31:0] dmem    [0:255];
  logic [31:0] ref_mem [0:255];

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference model: who owns the memory, how long the bridge has held it.
  bit          m_locked;
  int unsigned m_burst;
  bit          m_last_was_b;
  bit          m_c_rv, m_b_rv;
  logic [31:0] m_c_rd, m_b_rd;
  bit          m_gc_prev, m_gb_prev;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_LOCK(MAX_LOCK)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_stall(c_stall), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .b_req(b_req), .b_lock(b_lock), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural datamem: combinational read, write on the rising edge.
  assign mem_rdata = dmem[mem_addr[7:0]];
  always @(posedge clk) if (mem_we) dmem[mem_addr[7:0]] <= mem_wdata;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Who may use the memory this cycle given the current requests.
  function automatic void model_pick(output bit gc, output bit gb);
    bit c_turn;
    gc = 1'b0;
    gb = 1'b0;
    if (reset === 1'b1) begin
      if (m_locked) begin
        // bridge keeps the memory unless it is idle or has used up its burst
        c_turn = c_req && (!b_req || m_burst >= MAX_LOCK);
      end else begin
        // the core goes when alone, or when the bridge went last
        c_turn = c_req && (!b_req || m_last_was_b);
      end
      gc = c_turn;
      gb = b_req && !c_turn;
    end
  endfunction

  // Model update at each edge (or asynchronously on reset).
  always @(posedge clk or negedge reset) begin : model_blk
    bit gc, gb;
    if (!reset) begin
      m_locked = 1'b0; m_burst = 0; m_last_was_b = 1'b1;
      m_c_rv = 1'b0; m_b_rv = 1'b0; m_c_rd = '0; m_b_rd = '0;
      m_gc_prev = 1'b0; m_gb_prev = 1'b0;
    end else begin
      model_pick(gc, gb);
      m_gc_prev = gc;
      m_gb_prev = gb;
      if (gc || gb) m_last_was_b = gb;
      m_c_rv = gc && !c_we;
      m_b_rv = gb && !b_we;
      if (m_c_rv) m_c_rd = ref_mem[c_addr[7:0]];
      if (m_b_rv) m_b_rd = ref_mem[b_addr[7:0]];
      if (gc && c_we) ref_mem[c_addr[7:0]] = c_wdata;
      if (gb && b_we) ref_mem[b_addr[7:0]] = b_wdata;
      if (m_locked) begin
        if (gb) m_burst = (m_burst < MAX_LOCK) ? m_burst + 1 : MAX_LOCK;
        else if (gc) m_burst = 0;
        if (!(b_req && b_lock)) begin
          m_locked = 1'b0;
          m_burst  = 0;
        end
      end else if (gb && b_lock) begin
        m_locked = 1'b1;
        m_burst  = 1;
      end
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin : cmp_blk
    bit gc, gb;
    logic [31:0] ea, ed;
    logic        ewe;
    if (chk_en) begin
      model_pick(gc, gb);
      ewe = (gc && c_we) || (gb && b_we);
      ea  = gc ? c_addr : (gb ? b_addr : 32'h0);
      ed  = gc ? c_wdata : (gb ? b_wdata : 32'h0);
      chk1("c_gnt", c_gnt, gc);
      chk1("b_gnt", b_gnt, gb);
      chk1("c_stall", c_stall, c_req && !gc);
      chk1("mem_we", mem_we, ewe);
      chk32("mem_addr", mem_addr, ea);
      chk32("mem_wdata", mem_wdata, ed);
      chk1("c_rvalid", c_rvalid, m_c_rv);
      chk1("b_rvalid", b_rvalid, m_b_rv);
      chk32("c_rdata", c_rdata, m_c_rd);
      chk32("b_rdata", b_rdata, m_b_rd);
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  logic [5:0]  pat_c3, pat_s3;
  logic [17:0] pat_s4;

  initial begin
    for (int i = 0; i < 256; i++) begin
      dmem[i]    = 32'hA5A50000 | 32'(i);
      ref_mem[i] = 32'hA5A50000 | 32'(i);
    end

    // Reset held with both requesting (both writes): nothing may be granted.
    c_req = 1'b1; c_we = 1'b1; c_addr = 32'h40; c_wdata = 32'h11111111;
    b_req = 1'b1; b_we = 1'b1; b_addr = 32'h44; b_wdata = 32'h22222222;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(negedge clk);
    chk1("t1_c_gnt_rst", c_gnt, 1'b0);
    chk1("t1_b_gnt_rst", b_gnt, 1'b0);
    chk1("t1_mem_we_rst", mem_we, 1'b0);
    chk1("t1_c_rvalid_rst", c_rvalid, 1'b0);
    chk1("t1_b_rvalid_rst", b_rvalid, 1'b0);
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    chk1("t1_first_c", c_gnt, 1'b1);
    next_cycle();
    c_req = 1'b0;
    @(negedge clk);
    chk1("t1_then_b", b_gnt, 1'b1);
    next_cycle();
    b_req = 1'b0;

    // Core store then load of the same word.
    c_req = 1'b1; c_we = 1'b1; c_addr = 32'h10; c_wdata = 32'hDEADBEEF;
    @(negedge clk);
    chk1("t2_store_gnt", c_gnt, 1'b1);
    chk1("t2_store_we", mem_we, 1'b1);
    chk32("t2_store_addr", mem_addr, 32'h10);
    next_cycle();
    c_we = 1'b0;
    @(negedge clk);
    chk1("t2_load_gnt", c_gnt, 1'b1);
    chk1("t2_load_we", mem_we, 1'b0);
    next_cycle();
    c_req = 1'b0;
    @(negedge clk);
    chk1("t2_rvalid", c_rvalid, 1'b1);
    chk32("t2_rdata", c_rdata, 32'hDEADBEEF);
    next_cycle();
    @(negedge clk);
    chk1("t2_rvalid_drop", c_rvalid, 1'b0);
    next_cycle();

    // Make B the last winner, then alternate with both requesting, no lock.
    b_req = 1'b1; b_we = 1'b0; b_addr = 32'h30; b_lock = 1'b0;
    next_cycle();
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      pat_c3[i] = c_gnt;
      pat_s3[i] = c_stall;
      next_cycle();
    end
    chk32("t3_gnt_pattern", 32'(pat_c3), 32'(6'b010101));
    chk32("t3_stall_pattern", 32'(pat_s3), 32'(6'b101010));
    b_req = 1'b0;

    // C alone (last=C), then a locked B burst with C waiting.
    next_cycle();
    b_req = 1'b1; b_lock = 1'b1;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      pat_s4[i] = c_stall;
      next_cycle();
    end
    chk32("t4_stall_pattern", 32'(pat_s4), 32'(18'b011111111011111111));

    // Lock drop: B takes its last locked grant, C wins right after.
    c_req = 1'b0;
    next_cycle();
    c_req = 1'b1; b_lock = 1'b0;
    @(negedge clk);
    chk1("t5_drop_b_gnt", b_gnt, 1'b1);
    next_cycle();
    @(negedge clk);
    chk1("t5_c_after_exit", c_gnt, 1'b1);
    next_cycle();
    c_req = 1'b0; b_req = 1'b0;

    // Reset mid-cycle during a B write to 0x20 blocks that write.
    b_req = 1'b1; b_we = 1'b1; b_addr = 32'h20; b_wdata = 32'h12345678; b_lock = 1'b0;
    #2;
    chk1("t6_pre_gnt", b_gnt, 1'b1);
    chk1("t6_pre_we", mem_we, 1'b1);
    reset = 1'b0;
    #1;
    chk1("t6_we_drop", mem_we, 1'b0);
    chk1("t6_gnt_drop", b_gnt, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1; b_we = 1'b0;
    @(negedge clk);
    chk1("t6_read_gnt", b_gnt, 1'b1);
    next_cycle();
    b_req = 1'b0;
    @(negedge clk);
    chk1("t6_rvalid", b_rvalid, 1'b1);
    chk32("t6_old_value", b_rdata, 32'hA5A50020);

    // Random traffic with held requests and occasional mid-cycle resets.
    for (int n = 0; n < 3000; n++) begin
      next_cycle();
      if (!c_req || m_gc_prev) begin
        c_req = ($urandom_range(0, 3) != 0);
        c_we = 1'($urandom_range(0, 1)); c_addr = $urandom(); c_wdata = $urandom();
      end
      if (!b_req || m_gb_prev) begin
        b_req = ($urandom_range(0, 7) != 0);
        b_we = 1'($urandom_range(0, 1)); b_addr = $urandom(); b_wdata = $urandom();
      end
      b_lock = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 399) == 0) begin
        #2 reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
      end
    end

    next_cycle();
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
